// File: rtl/fc_out_layer.sv
// Output fully connected layer: buffers one feature vector, MACs it against the
// weight ROM for each class, then emits one saturated, requantised score per class.
//
// state | meaning
// LOAD  | accept N_IN features into the buffer
// MAC   | issue N_IN ROM reads for the current class, then one drain cycle
// EMIT  | present the registered class score for one cycle
module fc_out_layer #(
    parameter int BIT     = 8,
    parameter int N_IN    = 16,
    parameter int N_CLASS = 10,
    parameter int SHIFT   = 7,
    parameter int ACC_W   = 2*BIT + $clog2(N_IN)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [BIT-1:0]             in_data,
    output logic                              w_en,
    output logic [$clog2(N_CLASS*N_IN)-1:0]   w_addr,
    input  logic signed [BIT-1:0]             w_data,
    output logic                              score_valid,
    output logic                              score_first,
    output logic                              score_last,
    output logic signed [BIT-1:0]             score,
    output logic [3:0]                        score_idx,
    output logic                              busy
);

    localparam int AW = $clog2(N_CLASS*N_IN);
    localparam int FW = $clog2(N_IN);
    localparam int TW = $clog2(N_IN+1);
    localparam int CW = 4;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (BIT-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {LOAD, MAC, EMIT} state_t;

    state_t                  state_q;
    logic [FW-1:0]           feat_cnt_q;
    logic [TW-1:0]           tap_q;
    logic [CW-1:0]           cls_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [BIT-1:0]   fbuf_q [N_IN];

    logic                    score_valid_q;
    logic                    score_first_q;
    logic                    score_last_q;
    logic signed [BIT-1:0]   score_q;
    logic [CW-1:0]           score_idx_q;

    logic [FW-1:0]           rd_idx;
    logic signed [2*BIT-1:0] prod;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_shr;
    logic signed [BIT-1:0]   score_d;

    // w_data always answers the address issued one tap earlier
    always_comb begin
        rd_idx  = FW'(tap_q - TW'(1));
        prod    = (2*BIT)'(fbuf_q[rd_idx]) * (2*BIT)'(w_data);
        acc_d   = (tap_q == TW'(1)) ? ACC_W'(prod) : acc_q + ACC_W'(prod);
        acc_shr = acc_d >>> SHIFT;
        if (acc_shr > SAT_MAX) begin
            score_d = SAT_MAX[BIT-1:0];
        end else if (acc_shr < SAT_MIN) begin
            score_d = SAT_MIN[BIT-1:0];
        end else begin
            score_d = acc_shr[BIT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= LOAD;
            feat_cnt_q    <= '0;
            tap_q         <= '0;
            cls_q         <= '0;
            acc_q         <= '0;
            score_valid_q <= 1'b0;
            score_first_q <= 1'b0;
            score_last_q  <= 1'b0;
            score_q       <= '0;
            score_idx_q   <= '0;
        end else begin
            score_valid_q <= 1'b0;
            score_first_q <= 1'b0;
            score_last_q  <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        if (feat_cnt_q == FW'(N_IN-1)) begin
                            feat_cnt_q <= '0;
                            cls_q      <= '0;
                            tap_q      <= '0;
                            state_q    <= MAC;
                        end else begin
                            feat_cnt_q <= feat_cnt_q + FW'(1);
                        end
                    end
                end
                MAC: begin
                    if (tap_q != '0) begin
                        acc_q <= acc_d;
                    end
                    if (tap_q == TW'(N_IN)) begin
                        tap_q         <= '0;
                        score_valid_q <= 1'b1;
                        score_first_q <= (cls_q == '0);
                        score_last_q  <= (cls_q == CW'(N_CLASS-1));
                        score_q       <= score_d;
                        score_idx_q   <= cls_q;
                        state_q       <= EMIT;
                    end else begin
                        tap_q <= tap_q + TW'(1);
                    end
                end
                EMIT: begin
                    if (cls_q == CW'(N_CLASS-1)) begin
                        cls_q   <= '0;
                        state_q <= LOAD;
                    end else begin
                        cls_q   <= cls_q + CW'(1);
                        state_q <= MAC;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    // Feature storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (rst_n && state_q == LOAD && in_valid) begin
            fbuf_q[feat_cnt_q] <= in_data;
        end
    end

    assign in_ready    = (state_q == LOAD);
    assign busy        = (state_q != LOAD);
    assign w_en        = (state_q == MAC) && (tap_q < TW'(N_IN));
    assign w_addr      = AW'(cls_q) * AW'(N_IN) + AW'(tap_q);
    assign score_valid = score_valid_q;
    assign score_first = score_first_q;
    assign score_last  = score_last_q;
    assign score       = score_q;
    assign score_idx   = score_idx_q;

endmodule

// File: tb/tb_fc_out_layer.sv
// Directed bench for fc_out_layer: ramp, saturation, floor rounding, handshake,
// mid-run reset and ROM address sequencing, with hand-computed expectations.
module tb_fc_out_layer;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] in_data = '0;
    logic              w_en;
    logic [7:0]        w_addr;
    logic signed [7:0] w_data = '0;
    logic              score_valid, score_first, score_last, busy;
    logic signed [7:0] score;
    logic [3:0]        score_idx;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic signed [7:0] rom  [160];
    logic signed [7:0] feat [16];

    typedef struct {
        logic signed [7:0] s;
        logic [3:0]        idx;
        logic              f;
        logic              l;
        int                c;
    } strobe_t;

    strobe_t st_q[$];
    int      addr_q[$];
    int      run_q[$];
    int      wen_bad, xfers, rdy_low, busy_cnt, run_len;

    fc_out_layer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .score_valid(score_valid), .score_first(score_first), .score_last(score_last),
        .score(score), .score_idx(score_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    // cycle counter and one-cycle-latency weight ROM
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (w_en) w_data <= rom[w_addr];
    end

    always @(negedge clk) begin
        strobe_t e;
        if (score_valid) begin
            e.s = score; e.idx = score_idx; e.f = score_first; e.l = score_last; e.c = cyc;
            st_q.push_back(e);
        end
        if (w_en) begin
            addr_q.push_back(int'(w_addr));
            run_len++;
            if (in_ready || score_valid) wen_bad++;
        end else if (run_len != 0) begin
            run_q.push_back(run_len);
            run_len = 0;
        end
        if (in_valid && in_ready) xfers++;
        if (!in_ready) rdy_low++;
        if (busy) busy_cnt++;
    end

    task automatic clear_logs();
        st_q.delete(); addr_q.delete(); run_q.delete();
        wen_bad = 0; xfers = 0; rdy_low = 0; busy_cnt = 0; run_len = 0;
    endtask

    task automatic set_feat(input logic signed [7:0] v);
        for (int i = 0; i < 16; i++) feat[i] = v;
    endtask

    task automatic set_rom_const(input logic signed [7:0] v);
        for (int i = 0; i < 160; i++) rom[i] = v;
    endtask

    task automatic set_ramp();
        set_feat(8'sd8);
        for (int c = 0; c < 10; c++)
            for (int k = 0; k < 16; k++) rom[c*16+k] = 8'(c);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    // Drives the 16 features; t_last is the cycle of the final transfer (-1 on timeout)
    task automatic load_vector(input bit gaps, input bit hold, output int t_last);
        int i = 0;
        int guard = 0;
        bit ph = 1'b1;
        t_last = -1;
        while (i < 16 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
            in_valid = gaps ? ph : 1'b1;
            ph = !ph;
            in_data = feat[i];
            @(negedge clk);
            if (in_valid && in_ready) begin
                i++;
                t_last = cyc;
            end
        end
        @(posedge clk); #1;
        in_data = 8'sh55;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_assert++; if (score_valid !== 1'b0) begin n_fail++; $display("FAIL reset_score_valid: got %b want 0", score_valid); end
        n_assert++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL reset_w_en: got %b want 0", w_en); end
        n_assert++; if (w_addr !== 8'd0) begin n_fail++; $display("FAIL reset_w_addr: got %0d want 0", w_addr); end
        n_assert++; if (score !== 8'sd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", score); end
        n_assert++; if (score_idx !== 4'd0) begin n_fail++; $display("FAIL reset_score_idx: got %0d want 0", score_idx); end
        n_assert++; if ({score_first, score_last} !== 2'b00) begin n_fail++; $display("FAIL reset_first_last: got %b want 00", {score_first, score_last}); end
    endtask

    task automatic test_ramp();
        int t;
        set_ramp();
        clear_logs();
        load_vector(1'b0, 1'b0, t);
        n_assert++; if (t < 0) begin n_fail++; $display("FAIL ramp_load: got t=%0d want >=0", t); return; end
        run_to(t + 181);
        @(negedge clk); #1;
        n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ramp_ready_after: got %b want 1", in_ready); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ramp_busy_after: got %b want 0", busy); end
        n_assert++; if (busy_cnt !== 180) begin n_fail++; $display("FAIL ramp_busy_cycles: got %0d want 180", busy_cnt); end
        n_assert++; if (st_q.size() !== 10) begin n_fail++; $display("FAIL ramp_count: got %0d want 10", st_q.size()); end
        for (int c = 0; c < st_q.size() && c < 10; c++) begin
            n_assert++; if (st_q[c].s !== 8'(c)) begin n_fail++; $display("FAIL ramp_score[%0d]: got %0d want %0d", c, st_q[c].s, c); end
            n_assert++; if (st_q[c].idx !== 4'(c)) begin n_fail++; $display("FAIL ramp_idx[%0d]: got %0d want %0d", c, st_q[c].idx, c); end
            n_assert++; if (st_q[c].f !== (c == 0)) begin n_fail++; $display("FAIL ramp_first[%0d]: got %b want %b", c, st_q[c].f, c == 0); end
            n_assert++; if (st_q[c].l !== (c == 9)) begin n_fail++; $display("FAIL ramp_last[%0d]: got %b want %b", c, st_q[c].l, c == 9); end
            n_assert++; if (st_q[c].c !== t + 18 + 18*c) begin n_fail++; $display("FAIL ramp_time[%0d]: got %0d want %0d", c, st_q[c].c, t + 18 + 18*c); end
        end
        n_assert++; if (addr_q.size() !== 160) begin n_fail++; $display("FAIL rom_addr_count: got %0d want 160", addr_q.size()); end
        for (int i = 0; i < addr_q.size() && i < 160; i++) begin
            n_assert++; if (addr_q[i] !== i) begin n_fail++; $display("FAIL rom_addr[%0d]: got %0d want %0d", i, addr_q[i], i); end
        end
        n_assert++; if (run_q.size() !== 10) begin n_fail++; $display("FAIL rom_runs: got %0d want 10", run_q.size()); end
        for (int i = 0; i < run_q.size(); i++) begin
            n_assert++; if (run_q[i] !== 16) begin n_fail++; $display("FAIL rom_run_len[%0d]: got %0d want 16", i, run_q[i]); end
        end
        n_assert++; if (wen_bad !== 0) begin n_fail++; $display("FAIL rom_wen_in_load_emit: got %0d want 0", wen_bad); end
    endtask

    task automatic test_saturation();
        int t;
        logic signed [7:0] exp_v;
        for (int pass = 0; pass < 2; pass++) begin
            set_feat(8'sd127);
            set_rom_const(pass == 0 ? 8'sd127 : -8'sd128);
            exp_v = (pass == 0) ? 8'sd127 : -8'sd128;
            clear_logs();
            load_vector(1'b0, 1'b0, t);
            n_assert++; if (t < 0) begin n_fail++; $display("FAIL sat_load: got t=%0d want >=0", t); return; end
            run_to(t + 181);
            n_assert++; if (st_q.size() !== 10) begin n_fail++; $display("FAIL sat_count[%0d]: got %0d want 10", pass, st_q.size()); end
            for (int c = 0; c < st_q.size(); c++) begin
                n_assert++; if (st_q[c].s !== exp_v) begin n_fail++; $display("FAIL sat_score[%0d][%0d]: got %0d want %0d", pass, c, st_q[c].s, exp_v); end
            end
        end
    endtask

    task automatic test_floor();
        int t;
        set_feat(8'sd1);
        set_rom_const(8'sd0);
        rom[48] = -8'sd1;
        clear_logs();
        load_vector(1'b0, 1'b0, t);
        n_assert++; if (t < 0) begin n_fail++; $display("FAIL floor_load: got t=%0d want >=0", t); return; end
        run_to(t + 181);
        n_assert++; if (st_q.size() !== 10) begin n_fail++; $display("FAIL floor_count: got %0d want 10", st_q.size()); end
        for (int c = 0; c < st_q.size(); c++) begin
            n_assert++;
            if (st_q[c].s !== ((c == 3) ? -8'sd1 : 8'sd0)) begin
                n_fail++; $display("FAIL floor_score[%0d]: got %0d want %0d", c, st_q[c].s, (c == 3) ? -1 : 0);
            end
        end
    endtask

    task automatic test_handshake();
        int t;
        set_ramp();
        clear_logs();
        load_vector(1'b1, 1'b1, t);
        n_assert++; if (t < 0) begin n_fail++; $display("FAIL hs_load: got t=%0d want >=0", t); return; end
        run_to(t + 181);
        in_valid = 1'b0;
        @(negedge clk); #1;
        n_assert++; if (xfers !== 16) begin n_fail++; $display("FAIL hs_transfers: got %0d want 16", xfers); end
        n_assert++; if (rdy_low !== 180) begin n_fail++; $display("FAIL hs_ready_low: got %0d want 180", rdy_low); end
        n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hs_ready_after: got %b want 1", in_ready); end
        n_assert++; if (st_q.size() !== 10) begin n_fail++; $display("FAIL hs_count: got %0d want 10", st_q.size()); end
        for (int c = 0; c < st_q.size(); c++) begin
            n_assert++; if (st_q[c].s !== 8'(c)) begin n_fail++; $display("FAIL hs_score[%0d]: got %0d want %0d", c, st_q[c].s, c); end
        end
    endtask

    task automatic test_reset_mid();
        int t;
        int nl;
        set_ramp();
        clear_logs();
        load_vector(1'b0, 1'b0, t);
        n_assert++; if (t < 0) begin n_fail++; $display("FAIL rmid_load: got t=%0d want >=0", t); return; end
        run_to(t + 80);
        rst_n = 1'b0;
        run_to(t + 81);
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_assert++; if (score_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_score_valid: got %b want 0", score_valid); end
        n_assert++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL rmid_w_en: got %b want 0", w_en); end
        run_to(t + 200);
        nl = 0;
        foreach (st_q[i]) if (st_q[i].l) nl++;
        n_assert++; if (st_q.size() !== 4) begin n_fail++; $display("FAIL rmid_partial_count: got %0d want 4", st_q.size()); end
        n_assert++; if (nl !== 0) begin n_fail++; $display("FAIL rmid_no_last: got %0d want 0", nl); end
        clear_logs();
        load_vector(1'b0, 1'b0, t);
        n_assert++; if (t < 0) begin n_fail++; $display("FAIL rmid_reload: got t=%0d want >=0", t); return; end
        run_to(t + 181);
        n_assert++; if (st_q.size() !== 10) begin n_fail++; $display("FAIL rmid_count: got %0d want 10", st_q.size()); end
        for (int c = 0; c < st_q.size(); c++) begin
            n_assert++; if (st_q[c].s !== 8'(c)) begin n_fail++; $display("FAIL rmid_score[%0d]: got %0d want %0d", c, st_q[c].s, c); end
            n_assert++; if (st_q[c].idx !== 4'(c)) begin n_fail++; $display("FAIL rmid_idx[%0d]: got %0d want %0d", c, st_q[c].idx, c); end
        end
    endtask

    initial begin
        set_rom_const(8'sd0);
        set_feat(8'sd0);
        clear_logs();
        test_reset();
        test_ramp();
        test_saturation();
        test_floor();
        test_handshake();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
